ble_pdu_deframer: RTL and testbench

- Sits directly downstream of the packet sniffer on the demodulated bit stream.
- Runs on the 16 MHz system clock. Samples the symbol stream on rising edges of the timing-recovery `update` strobe.
- After an access-address match it dewhitens the PDU and assembles bytes LSB-first. It takes the length from the PDU header, checks the CRC-24, and presents payload bytes through a valid/ready FIFO to the host/readout logic.

---
 rtl/ble_pdu_deframer.sv | 205 ++++++++++++++++++++
 tb/tb_ble_pdu_deframer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_pdu_deframer.sv
// BLE PDU deframer: dewhitens the demodulated bit stream after an access-address
// match, assembles bytes LSB-first, parses the header length, checks CRC-24 and
// queues header/payload bytes in a small valid/ready output FIFO.
module ble_pdu_deframer #(
   parameter int          MAX_PAYLOAD = 37,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [23:0] CRC_POLY    = 24'h00065B,
   parameter logic [23:0] CRC_INIT    = 24'h555555
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       update,
   input  logic       symbol_in,
   input  logic       acc_match,
   input  logic [5:0] channel,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       busy,
   output logic       pkt_done,
   output logic       crc_ok,
   output logic       len_err,
   output logic       overflow
);

   localparam int            AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [7:0]    MAX_LEN  = 8'(MAX_PAYLOAD);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CRC, S_DONE} state_t;

   state_t        state, state_next;
   logic          upd_d, acc_d;
   logic          sym_tick, start, consume;
   logic [6:0]    whit, whit_next, whit_seed;
   logic [23:0]   crc, crc_data_next;
   logic [15:0]   bit_cnt;
   logic [7:0]    shreg, len, byte_new;
   logic          mismatch, d, fb, last_pl;
   logic          push, cnt_clr, abort, finish;
   logic          push_ok, pop, full;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    mem [FIFO_DEPTH];

   assign sym_tick = update & ~upd_d;
   assign start    = acc_match & ~acc_d & en;
   // A tick coincident with the start edge belongs to nobody and is dropped.
   assign consume  = sym_tick & en & ~start &
                     ((state == S_HDR) | (state == S_PAYLOAD) | (state == S_CRC));
   assign d        = symbol_in ^ whit[6];
   assign byte_new = {d, shreg[7:1]};
   assign fb       = crc[23] ^ d;
   assign crc_data_next = {crc[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'd0);
   assign last_pl  = (bit_cnt == ({5'd0, len, 3'd0} - 16'd1));
   assign busy     = (state != S_IDLE);

   // Whitening seed: w0 = 1, w1..w6 take channel[5..0] in reverse order.
   assign whit_seed[0] = 1'b1;
   for (genvar gi = 0; gi < 6; gi++) begin : g_seed
      assign whit_seed[gi+1] = channel[5-gi];
   end

   // Whitening LFSR advance: plain shift with w6 fed back into w0 and w4.
   always_comb begin
      whit_next    = {whit[5:0], whit[6]};
      whit_next[4] = whit[3] ^ whit[6];
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   // Next-state logic plus per-tick control strobes for the datapath.
   always_comb begin
      state_next = state;
      push       = 1'b0;
      cnt_clr    = 1'b0;
      abort      = 1'b0;
      finish     = 1'b0;
      if (!en) begin
         state_next = S_IDLE;
      end else if (start) begin
         state_next = S_HDR;
      end else begin
         case (state)
            S_IDLE: state_next = S_IDLE;
            S_HDR: if (consume) begin
               push = (bit_cnt[2:0] == 3'd7);
               if (bit_cnt == 16'd15) begin
                  cnt_clr = 1'b1;
                  if (byte_new > MAX_LEN) begin
                     abort      = 1'b1;
                     state_next = S_IDLE;
                  end else if (byte_new == 8'd0) begin
                     state_next = S_CRC;
                  end else begin
                     state_next = S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: if (consume) begin
               push = (bit_cnt[2:0] == 3'd7);
               if (last_pl) begin
                  cnt_clr    = 1'b1;
                  state_next = S_CRC;
               end
            end
            S_CRC: if (consume && bit_cnt == 16'd23) begin
               finish     = 1'b1;
               state_next = S_DONE;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Bit datapath: edge detectors, dewhitening, byte shift, CRC and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         upd_d    <= 1'b0;
         acc_d    <= 1'b0;
         whit     <= 7'd0;
         crc      <= 24'd0;
         bit_cnt  <= 16'd0;
         shreg    <= 8'd0;
         len      <= 8'd0;
         mismatch <= 1'b0;
         pkt_done <= 1'b0;
         crc_ok   <= 1'b0;
         len_err  <= 1'b0;
      end else begin
         upd_d    <= update;
         acc_d    <= acc_match;
         pkt_done <= 1'b0;
         if (start) begin
            whit     <= whit_seed;
            crc      <= CRC_INIT;
            bit_cnt  <= 16'd0;
            mismatch <= 1'b0;
            crc_ok   <= 1'b0;
            len_err  <= 1'b0;
         end else if (consume) begin
            whit    <= whit_next;
            shreg   <= byte_new;
            bit_cnt <= cnt_clr ? 16'd0 : bit_cnt + 16'd1;
            if (state == S_HDR && bit_cnt == 16'd15) len <= byte_new;
            if (state == S_CRC) begin
               crc      <= {crc[22:0], 1'b0};
               mismatch <= mismatch | (d ^ crc[23]);
            end else begin
               crc <= crc_data_next;
            end
            if (abort) begin
               len_err  <= 1'b1;
               crc_ok   <= 1'b0;
               pkt_done <= 1'b1;
            end
            if (finish) begin
               pkt_done <= 1'b1;
               crc_ok   <= ~(mismatch | (d ^ crc[23]));
            end
         end
      end
   end

   assign pop        = byte_valid & byte_ready;
   assign full       = (count == CNT_FULL);
   // A simultaneous pop frees a slot, so a push at full is still accepted then.
   assign push_ok    = push & (~full | pop);
   assign byte_valid = (count != '0);
   assign byte_out   = byte_valid ? mem[rd_ptr] : 8'h00;

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (start)                     overflow <= 1'b0;
         else if (push & full & ~pop)   overflow <= 1'b1;
      end
   end

   // FIFO storage; contents need no reset because byte_out is gated by valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= byte_new;
   end

endmodule

// File: tb/tb_ble_pdu_deframer.sv
// Scoreboard bench for ble_pdu_deframer: a transmitter model whitens and
// CRC-protects directed packets, expected bytes/packet results go into queues,
// and a monitor pops and compares whenever the DUT presents an output.
module tb_ble_pdu_deframer;

   logic       clk = 1'b0;
   logic       rst, en, update, symbol_in, acc_match, byte_ready;
   logic [5:0] channel;
   logic [7:0] byte_out;
   logic       byte_valid, busy, pkt_done, crc_ok, len_err, overflow;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q [$];
   logic [1:0]  pkt_q [$];   // {crc_ok, len_err}
   logic [7:0]  pkt [0:15];
   logic [6:0]  wl;
   logic [23:0] cm;

   ble_pdu_deframer dut (
      .clk(clk), .rst(rst), .en(en), .update(update), .symbol_in(symbol_in),
      .acc_match(acc_match), .channel(channel), .byte_out(byte_out),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
      .pkt_done(pkt_done), .crc_ok(crc_ok), .len_err(len_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every accepted byte and every pkt_done against the queues.
   always begin
      @(negedge clk);
      #1;
      if (byte_valid && byte_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got %02h expected none", byte_out);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            $display("byte out %02h expected %02h", byte_out, e);
            chk("byte", {24'd0, byte_out}, {24'd0, e});
         end
      end
      if (pkt_done) begin
         if (pkt_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pkt_done: got crc_ok=%0b len_err=%0b expected none", crc_ok, len_err);
         end else begin
            logic [1:0] p;
            p = pkt_q.pop_front();
            $display("pkt_done crc_ok=%0b len_err=%0b expected %0b %0b", crc_ok, len_err, p[1], p[0]);
            chk("pkt_status", {30'd0, crc_ok, len_err}, {30'd0, p});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic drive_sym(input logic s);
      @(negedge clk); update = 1'b1; symbol_in = s;
      @(negedge clk); update = 1'b0;
   endtask

   task automatic wstep(output logic o);
      logic [6:0] n;
      o    = wl[6];
      n[0] = wl[6];
      n[1] = wl[0];
      n[2] = wl[1];
      n[3] = wl[2];
      n[4] = wl[3] ^ wl[6];
      n[5] = wl[4];
      n[6] = wl[5];
      wl   = n;
   endtask

   task automatic start_pkt(input logic [5:0] ch);
      channel = ch;
      wl[0] = 1'b1;
      for (int k = 1; k < 7; k++) wl[k] = ch[6-k];
      cm = 24'h555555;
      @(negedge clk); acc_match = 1'b1;
      @(negedge clk); acc_match = 1'b0;
   endtask

   task automatic send_raw(input logic r);
      logic w;
      wstep(w);
      drive_sym(r);
   endtask

   // CRC covers the intended bit; the flip mask corrupts only what goes on air.
   task automatic send_byte(input logic [7:0] b, input logic [7:0] flip);
      logic w, f;
      for (int i = 0; i < 8; i++) begin
         wstep(w);
         f  = cm[23] ^ b[i];
         cm = {cm[22:0], 1'b0} ^ (f ? 24'h00065B : 24'h000000);
         drive_sym(b[i] ^ flip[i] ^ w);
      end
   endtask

   task automatic send_crc();
      logic w, c;
      for (int i = 0; i < 24; i++) begin
         wstep(w);
         c  = cm[23];
         cm = {cm[22:0], 1'b0};
         drive_sym(c ^ w);
      end
   endtask

   task automatic send_good(input int nb, input int flip_idx, input logic [7:0] flip_mask,
                            input int n_expect, input logic exp_ok);
      logic [7:0] fm;
      for (int i = 0; i < nb; i++) begin
         fm = (i == flip_idx) ? flip_mask : 8'h00;
         if (i < n_expect) exp_q.push_back(pkt[i] ^ fm);
         send_byte(pkt[i], fm);
         if (i == 0) chk("byte_latency", {31'd0, byte_valid}, 32'd1);
      end
      pkt_q.push_back({exp_ok, 1'b0});
      send_crc();
      chk("pkt_done_latency", {31'd0, pkt_done}, 32'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk); #2; n++;
      end
      chk("drain_left", exp_q.size(), 32'd0);
      @(negedge clk); #1;
   endtask

   task automatic load_adv();
      pkt[0] = 8'h40; pkt[1] = 8'h06; pkt[2] = 8'h66; pkt[3] = 8'h55;
      pkt[4] = 8'h44; pkt[5] = 8'h33; pkt[6] = 8'h22; pkt[7] = 8'h11;
   endtask

   initial begin
      logic       w;
      logic [7:0] b55;
      rst = 1'b0; en = 1'b1; update = 1'b0; symbol_in = 1'b0; acc_match = 1'b0;
      channel = 6'd0; byte_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {18'd0, byte_out, byte_valid, busy, pkt_done, crc_ok, len_err, overflow}, 32'd0);
      @(negedge clk); rst = 1'b1;

      // Good ADV_IND on channel 37.
      load_adv();
      start_pkt(6'd37);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      send_good(8, -1, 8'h00, 8, 1'b1);
      wait_drain();
      chk("good_crc_ok_held", {31'd0, crc_ok}, 32'd1);
      chk("good_idle", {31'd0, busy}, 32'd0);

      // Payload bit 20 flipped on air (byte 0x44 bit 4).
      start_pkt(6'd37);
      send_good(8, 4, 8'h10, 8, 1'b0);
      wait_drain();
      chk("corrupt_crc_ok", {31'd0, crc_ok}, 32'd0);

      // Channel 0, raw zeros: dewhitened header 40 B2, length 0xB2 aborts.
      start_pkt(6'd0);
      exp_q.push_back(8'h40); exp_q.push_back(8'hB2); pkt_q.push_back(2'b01);
      for (int i = 0; i < 16; i++) send_raw(1'b0);
      chk("ch0_abort_done", {31'd0, pkt_done}, 32'd1);
      chk("ch0_abort_len_err", {31'd0, len_err}, 32'd1);
      for (int i = 0; i < 16; i++) send_raw(1'b1);
      chk("ch0_ticks_ignored", {31'd0, busy}, 32'd0);
      wait_drain();

      // Channel 37, raw zeros then length 0x30: first byte 8D, abort after bit 15.
      start_pkt(6'd37);
      exp_q.push_back(8'h8D); exp_q.push_back(8'h30); pkt_q.push_back(2'b01);
      for (int i = 0; i < 8; i++) send_raw(1'b0);
      send_byte(8'h30, 8'h00);
      chk("len_abort_done", {31'd0, pkt_done}, 32'd1);
      chk("len_abort_idle", {31'd0, busy}, 32'd0);
      chk("len_abort_flags", {30'd0, crc_ok, len_err}, 32'd1);
      for (int i = 0; i < 24; i++) send_raw(1'b0);
      wait_drain();

      // Backpressure: whole packet held in an 8-deep FIFO, no overflow.
      byte_ready = 1'b0;
      start_pkt(6'd37);
      chk("start_clears_len_err", {31'd0, len_err}, 32'd0);
      send_good(8, -1, 8'h00, 8, 1'b1);
      chk("bp_no_overflow", {31'd0, overflow}, 32'd0);
      byte_ready = 1'b1;
      wait_drain();
      chk("bp_exactly_8", {31'd0, byte_valid}, 32'd0);

      // Length 8 (10 bytes) with no consumer: last two dropped, overflow set.
      pkt[0] = 8'h42; pkt[1] = 8'h08;
      for (int i = 0; i < 8; i++) pkt[i+2] = 8'(i + 1);
      byte_ready = 1'b0;
      start_pkt(6'd37);
      send_good(10, -1, 8'h00, 8, 1'b1);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      byte_ready = 1'b1;
      wait_drain();
      chk("ovf_exactly_8", {31'd0, byte_valid}, 32'd0);

      // Restart after 30 bits, then a full good packet.
      load_adv();
      start_pkt(6'd37);
      chk("start_clears_overflow", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(pkt[i]);
         send_byte(pkt[i], 8'h00);
      end
      b55 = 8'h55;
      for (int i = 0; i < 6; i++) begin
         wstep(w);
         drive_sym(b55[i] ^ w);
      end
      start_pkt(6'd37);
      send_good(8, -1, 8'h00, 8, 1'b1);
      wait_drain();
      chk("restart_crc_ok", {31'd0, crc_ok}, 32'd1);

      // Disable mid-header: idle next clk, no pkt_done, later ticks ignored.
      start_pkt(6'd37);
      exp_q.push_back(8'h40);
      send_byte(8'h40, 8'h00);
      for (int i = 0; i < 3; i++) send_raw(1'b0);
      en = 1'b0;
      @(negedge clk);
      chk("disable_idle", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) send_raw(1'b1);
      en = 1'b1;
      for (int i = 0; i < 12; i++) send_raw(1'b1);
      chk("disable_still_idle", {31'd0, busy}, 32'd0);
      wait_drain();

      // Reset mid-payload with bytes waiting in the FIFO.
      byte_ready = 1'b0;
      start_pkt(6'd37);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(pkt[i]);
         send_byte(pkt[i], 8'h00);
      end
      for (int i = 0; i < 4; i++) send_raw(1'b0);
      chk("pre_reset_valid", {31'd0, byte_valid}, 32'd1);
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("midrun_reset_outputs", {18'd0, byte_out, byte_valid, busy, pkt_done, crc_ok, len_err, overflow}, 32'd0);
      @(negedge clk); rst = 1'b1; byte_ready = 1'b1;

      // Recovery packet after reset.
      start_pkt(6'd37);
      send_good(8, -1, 8'h00, 8, 1'b1);
      wait_drain();

      repeat (4) @(negedge clk);
      chk("pkt_q_empty", pkt_q.size(), 32'd0);
      chk("exp_q_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
